ipv4_header_generator: RTL and testbench

Builds a 20-byte IPv4 header from latched field inputs, streams it through the `internet_checksum_calculator` to obtain the header checksum, then emits the finished header byte-serially, checksum inserted, to the UDP transmit path. It drives the calculator's byte input and consumes its result. It therefore sits both directly upstream and directly downstream of the checksum stage.

---
 rtl/ipv4_header_generator.sv | 192 +++++++++++++++++++
 tb/tb_ipv4_header_generator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_header_generator.sv
// IPv4 header generator: latches header fields, streams the 20-byte header through an
// external ones'-complement checksum calculator, then emits it with the checksum filled in.
module ipv4_header_generator (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] source_ip,
    input  logic [31:0] destination_ip,
    input  logic [15:0] payload_length,
    input  logic [15:0] identification,
    input  logic [7:0]  time_to_live,
    input  logic [7:0]  protocol,
    output logic [7:0]  checksum_data,
    output logic        checksum_data_enable,
    output logic        checksum_data_last,
    input  logic        checksum_ready,
    input  logic [15:0] checksum_result,
    input  logic        checksum_result_valid,
    output logic [7:0]  header_data,
    output logic        header_valid,
    output logic        header_last,
    input  logic        header_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX   = 5'd19;
    localparam logic [7:0] FIRST_BYTE = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CALC,
        S_FEED,
        S_WAIT_RESULT,
        S_EMIT
    } state_t;

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [31:0] r_src_ip;
    logic [31:0] r_dst_ip;
    logic [15:0] r_total_len;
    logic [15:0] r_ident;
    logic [7:0]  r_ttl;
    logic [7:0]  r_proto;
    logic [15:0] r_csum;

    logic [4:0]  w_idx_next;
    logic [7:0]  w_feed_byte;
    logic [7:0]  w_emit_byte;

    function automatic logic [7:0] hdr_byte(
        input logic [4:0]  idx,
        input logic [15:0] csum,
        input logic [15:0] total_len,
        input logic [15:0] ident,
        input logic [7:0]  ttl,
        input logic [7:0]  proto,
        input logic [31:0] src_ip,
        input logic [31:0] dst_ip
    );
        logic [7:0] b;
        case (idx)
            5'd0:    b = FIRST_BYTE;
            5'd1:    b = 8'h00;
            5'd2:    b = total_len[15:8];
            5'd3:    b = total_len[7:0];
            5'd4:    b = ident[15:8];
            5'd5:    b = ident[7:0];
            5'd6:    b = 8'h40;
            5'd7:    b = 8'h00;
            5'd8:    b = ttl;
            5'd9:    b = proto;
            5'd10:   b = csum[15:8];
            5'd11:   b = csum[7:0];
            5'd12:   b = src_ip[31:24];
            5'd13:   b = src_ip[23:16];
            5'd14:   b = src_ip[15:8];
            5'd15:   b = src_ip[7:0];
            5'd16:   b = dst_ip[31:24];
            5'd17:   b = dst_ip[23:16];
            5'd18:   b = dst_ip[15:8];
            5'd19:   b = dst_ip[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_idx_next = r_idx + 5'd1;

    // The calculator must see a zero checksum field; the emitted copy carries the inverted result.
    assign w_feed_byte = hdr_byte(w_idx_next, 16'h0000, r_total_len, r_ident, r_ttl, r_proto,
                                  r_src_ip, r_dst_ip);
    assign w_emit_byte = hdr_byte(w_idx_next, r_csum, r_total_len, r_ident, r_ttl, r_proto,
                                  r_src_ip, r_dst_ip);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state              <= S_IDLE;
            r_idx                <= 5'd0;
            r_src_ip             <= 32'd0;
            r_dst_ip             <= 32'd0;
            r_total_len          <= 16'd0;
            r_ident              <= 16'd0;
            r_ttl                <= 8'd0;
            r_proto              <= 8'd0;
            r_csum               <= 16'd0;
            checksum_data        <= 8'd0;
            checksum_data_enable <= 1'b0;
            checksum_data_last   <= 1'b0;
            header_data          <= 8'd0;
            header_valid         <= 1'b0;
            header_last          <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ip    <= source_ip;
                        r_dst_ip    <= destination_ip;
                        r_total_len <= payload_length + 16'd20;
                        r_ident     <= identification;
                        r_ttl       <= time_to_live;
                        r_proto     <= protocol;
                        r_idx       <= 5'd0;
                        busy        <= 1'b1;
                        r_state     <= S_WAIT_CALC;
                    end
                end

                S_WAIT_CALC: begin
                    if (checksum_ready) begin
                        checksum_data        <= FIRST_BYTE;
                        checksum_data_enable <= 1'b1;
                        checksum_data_last   <= 1'b0;
                        r_idx                <= 5'd0;
                        r_state              <= S_FEED;
                    end
                end

                // r_idx tracks the byte currently presented on checksum_data.
                S_FEED: begin
                    if (r_idx == LAST_IDX) begin
                        checksum_data        <= 8'd0;
                        checksum_data_enable <= 1'b0;
                        checksum_data_last   <= 1'b0;
                        r_state              <= S_WAIT_RESULT;
                    end else begin
                        checksum_data      <= w_feed_byte;
                        checksum_data_last <= (w_idx_next == LAST_IDX);
                        r_idx              <= w_idx_next;
                    end
                end

                S_WAIT_RESULT: begin
                    if (checksum_result_valid) begin
                        r_csum       <= ~checksum_result;
                        r_idx        <= 5'd0;
                        header_data  <= FIRST_BYTE;
                        header_valid <= 1'b1;
                        header_last  <= 1'b0;
                        r_state      <= S_EMIT;
                    end
                end

                // Output holds until accepted, so a stall needs no extra state.
                S_EMIT: begin
                    if (header_ready) begin
                        if (r_idx == LAST_IDX) begin
                            header_data  <= 8'd0;
                            header_valid <= 1'b0;
                            header_last  <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            r_idx        <= 5'd0;
                            r_state      <= S_IDLE;
                        end else begin
                            header_data <= w_emit_byte;
                            header_last <= (w_idx_next == LAST_IDX);
                            r_idx       <= w_idx_next;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_header_generator.sv
// Directed bench for ipv4_header_generator with a behavioural checksum calculator
// and hand-computed reference headers.
module tb_ipv4_header_generator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] source_ip = 32'd0;
    logic [31:0] destination_ip = 32'd0;
    logic [15:0] payload_length = 16'd0;
    logic [15:0] identification = 16'd0;
    logic [7:0]  time_to_live = 8'd0;
    logic [7:0]  protocol = 8'd0;
    logic [7:0]  checksum_data;
    logic        checksum_data_enable;
    logic        checksum_data_last;
    logic        checksum_ready = 1'b0;
    logic [15:0] checksum_result = 16'd0;
    logic        checksum_result_valid = 1'b0;
    logic [7:0]  header_data;
    logic        header_valid;
    logic        header_last;
    logic        header_ready = 1'b1;
    logic        busy;
    logic        done;

    ipv4_header_generator dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .start                 (start),
        .source_ip             (source_ip),
        .destination_ip        (destination_ip),
        .payload_length        (payload_length),
        .identification        (identification),
        .time_to_live          (time_to_live),
        .protocol              (protocol),
        .checksum_data         (checksum_data),
        .checksum_data_enable  (checksum_data_enable),
        .checksum_data_last    (checksum_data_last),
        .checksum_ready        (checksum_ready),
        .checksum_result       (checksum_result),
        .checksum_result_valid (checksum_result_valid),
        .header_data           (header_data),
        .header_valid          (header_valid),
        .header_last           (header_last),
        .header_ready          (header_ready),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clock = ~clock;

    // Hand-computed headers, byte 0 in the top byte.
    localparam logic [159:0] HDR_REF  = 160'h45000073_00004000_4011B861_C0A80001_C0A800C7;
    localparam logic [159:0] HDR_B    = 160'h45000114_12344000_8006D3AD_0A000001_0A000002;
    localparam logic [159:0] HDR_WRAP = 160'h45000004_00004000_4011B8D0_C0A80001_C0A800C7;
    localparam logic [159:0] HDR_ZERO = 160'h45000014_00004000_00007AEB_00000000_00000000;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural checksum calculator: sums 16-bit words, result_valid 3 cycles after the last byte.
    logic [31:0] m_sum = 32'd0;
    int          m_n   = 0;
    int          m_cd  = 0;
    logic [7:0]  fed[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            m_sum = 32'd0;
            m_n   = 0;
            m_cd  = 0;
            checksum_result_valid = 1'b0;
            checksum_result       = 16'd0;
        end else begin
            checksum_result_valid = 1'b0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) checksum_result_valid = 1'b1;
            end
            if (checksum_data_enable) begin
                fed.push_back(checksum_data);
                m_sum += (m_n % 2 == 0) ? {16'h0, checksum_data, 8'h00} : {24'h0, checksum_data};
                m_n++;
                if (checksum_data_last) begin
                    m_sum = (m_sum & 32'hFFFF) + (m_sum >> 16);
                    m_sum = (m_sum & 32'hFFFF) + (m_sum >> 16);
                    checksum_result = m_sum[15:0];
                    m_sum = 32'd0;
                    m_n   = 0;
                    m_cd  = 2;
                end
            end
        end
    end

    // Output collector with stall-stability and done-timing checks.
    logic [7:0] cap[$];
    logic       cap_last[$];
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_last_hs = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_lastflag = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", header_data, prev_data);
                chk("stall_last", header_last, prev_lastflag);
            end
            if (prev_last_hs) chk("done_after_last", done, 1);
            if (done) done_cnt++;
            if (header_valid && header_ready) begin
                cap.push_back(header_data);
                cap_last.push_back(header_last);
            end
            prev_stall    = header_valid && !header_ready;
            prev_data     = header_data;
            prev_lastflag = header_last;
            prev_last_hs  = header_valid && header_ready && header_last;
        end
    end

    // Backpressure pattern 1,0,0,1 on header_ready.
    logic bp_mode = 1'b0;
    int   bp_i = 0;
    always @(posedge clock) begin
        #1;
        if (bp_mode) begin
            header_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
            bp_i++;
        end
    end

    task automatic set_fields(input logic [31:0] s, input logic [31:0] d, input logic [15:0] pl,
                              input logic [15:0] id, input logic [7:0] ttl, input logic [7:0] pr);
        source_ip      = s;
        destination_ip = d;
        payload_length = pl;
        identification = id;
        time_to_live   = ttl;
        protocol       = pr;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (k < 400 && !done) begin
            @(negedge clock);
            k++;
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_done_pulse(input string tag);
        @(negedge clock);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_done_count"}, 32'(done_cnt), 1);
        done_cnt = 0;
    endtask

    task automatic clear_caps();
        cap.delete();
        cap_last.delete();
        fed.delete();
    endtask

    task automatic check_frame(input string tag, input logic [159:0] hdr);
        logic [7:0] e;
        chk({tag, "_nbytes"}, 32'(cap.size()), 20);
        chk({tag, "_nfed"}, 32'(fed.size()), 20);
        for (int i = 0; i < 20; i++) begin
            e = hdr[159 - 8*i -: 8];
            if (i < cap.size()) begin
                chk($sformatf("%s_out%0d", tag, i), cap[i], e);
                chk($sformatf("%s_last%0d", tag, i), cap_last[i], (i == 19));
            end
            if (i < fed.size())
                chk($sformatf("%s_fed%0d", tag, i), fed[i], (i == 10 || i == 11) ? 8'h00 : e);
        end
        clear_caps();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ck_data"}, checksum_data, 0);
        chk({tag, "_ck_en"}, checksum_data_enable, 0);
        chk({tag, "_ck_last"}, checksum_data_last, 0);
        chk({tag, "_hdr_data"}, header_data, 0);
        chk({tag, "_hdr_valid"}, header_valid, 0);
        chk({tag, "_hdr_last"}, header_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic reset_pulse(input string tag);
        reset_n = 1'b0;
        @(negedge clock);
        check_idle_outputs(tag);
        @(negedge clock);
        reset_n = 1'b1;
        clear_caps();
        done_cnt = 0;
    endtask

    initial begin
        // Reset values, then start on the first cycle after release with the calculator not ready.
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        set_fields(32'hC0A80001, 32'hC0A800C7, 16'h005F, 16'h0000, 8'h40, 8'h11);
        reset_n = 1'b1;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("postrst_busy", busy, 1);
        repeat (10) @(negedge clock);
        chk("postrst_hold_en", checksum_data_enable, 0);
        chk("postrst_hold_fed", 32'(fed.size()), 0);
        chk("postrst_hold_busy", busy, 1);
        checksum_ready = 1'b1;
        wait_done("ref");
        check_done_pulse("ref");
        check_frame("ref", HDR_REF);

        // Stray start during emit is ignored; a start right after done runs the next header.
        pulse_start();
        begin
            int k = 0;
            while (k < 200 && cap.size() < 3) begin
                @(negedge clock);
                k++;
            end
        end
        set_fields(32'h0A000001, 32'h0A000002, 16'h0100, 16'h1234, 8'h80, 8'h06);
        pulse_start();
        wait_done("b2b1");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_frame("b2b1", HDR_REF);
        done_cnt = 0;
        wait_done("b2b2");
        check_done_pulse("b2b2");
        check_frame("b2b2", HDR_B);
        repeat (30) @(negedge clock);
        chk("b2b_no_extra_busy", busy, 0);
        chk("b2b_no_extra_out", 32'(cap.size()), 0);

        // Backpressure on the reference header.
        set_fields(32'hC0A80001, 32'hC0A800C7, 16'h005F, 16'h0000, 8'h40, 8'h11);
        bp_mode = 1'b1;
        pulse_start();
        wait_done("bp");
        bp_mode = 1'b0;
        header_ready = 1'b1;
        check_done_pulse("bp");
        check_frame("bp", HDR_REF);

        // Total-length wrap, then an all-zero header.
        set_fields(32'hC0A80001, 32'hC0A800C7, 16'hFFF0, 16'h0000, 8'h40, 8'h11);
        pulse_start();
        wait_done("wrap");
        check_done_pulse("wrap");
        check_frame("wrap", HDR_WRAP);

        set_fields(32'h0, 32'h0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        pulse_start();
        wait_done("zero");
        check_done_pulse("zero");
        check_frame("zero", HDR_ZERO);

        // Reset at byte 10 of the feed, then a clean header.
        set_fields(32'hC0A80001, 32'hC0A800C7, 16'h005F, 16'h0000, 8'h40, 8'h11);
        pulse_start();
        begin
            int k = 0;
            while (k < 200 && fed.size() < 10) begin
                @(negedge clock);
                k++;
            end
        end
        reset_pulse("rst_feed");
        pulse_start();
        wait_done("after_rst_feed");
        check_done_pulse("after_rst_feed");
        check_frame("after_rst_feed", HDR_REF);

        // Reset at byte 5 of the emit, then a clean header with other fields.
        pulse_start();
        begin
            int k = 0;
            while (k < 200 && cap.size() < 5) begin
                @(negedge clock);
                k++;
            end
        end
        reset_pulse("rst_emit");
        set_fields(32'h0A000001, 32'h0A000002, 16'h0100, 16'h1234, 8'h80, 8'h06);
        pulse_start();
        wait_done("after_rst_emit");
        check_done_pulse("after_rst_emit");
        check_frame("after_rst_emit", HDR_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
